// File: rtl/wb_rr_arbiter_if.sv
// Bus bundle for wb_rr_arbiter: N master request/response lanes plus the shared slave port.
// modport master is the arbiter's view; modport slave is the environment (masters + memory).
interface wb_rr_arbiter_if #(
  parameter int unsigned N_MASTERS = 2,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32
);
  localparam int unsigned SEL_W = DATA_W / 8;

  // master-side lanes, master k occupies slice k
  logic [N_MASTERS-1:0]        m_cyc_i;
  logic [N_MASTERS-1:0]        m_stb_i;
  logic [N_MASTERS-1:0]        m_we_i;
  logic [N_MASTERS*SEL_W-1:0]  m_sel_i;
  logic [N_MASTERS*ADDR_W-1:0] m_adr_i;
  logic [N_MASTERS*DATA_W-1:0] m_dat_i;
  logic [DATA_W-1:0]           m_dat_o;
  logic [N_MASTERS-1:0]        m_ack_o;
  logic [N_MASTERS-1:0]        m_err_o;
  logic [N_MASTERS-1:0]        grant_o;

  // shared slave port
  logic                        s_cyc_o;
  logic                        s_stb_o;
  logic                        s_we_o;
  logic [SEL_W-1:0]            s_sel_o;
  logic [ADDR_W-1:0]           s_adr_o;
  logic [DATA_W-1:0]           s_dat_o;
  logic [DATA_W-1:0]           s_dat_i;
  logic                        s_ack_i;
  logic                        s_err_i;

  modport master (
    input  m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i,
    output m_dat_o, m_ack_o, m_err_o, grant_o,
    output s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
    input  s_dat_i, s_ack_i, s_err_i
  );

  modport slave (
    output m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i,
    input  m_dat_o, m_ack_o, m_err_o, grant_o,
    input  s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
    output s_dat_i, s_ack_i, s_err_i
  );
endinterface

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: N masters share one slave port, grant held until CYC drops,
// with a watchdog that turns a hung transfer into a one-cycle ERR to the granted master.
module wb_rr_arbiter #(
  parameter int unsigned N_MASTERS = 2,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic             clk,
  input  logic             rst_i,
  wb_rr_arbiter_if.master  bus
);

  localparam int unsigned SEL_W = DATA_W / 8;
  localparam int unsigned PTR_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam int unsigned WD_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_ABORT = 2'd2;

  if (N_MASTERS < 2 || (DATA_W % 8) != 0) begin : g_bad_param
    $error("wb_rr_arbiter: N_MASTERS must be >= 2 and DATA_W a multiple of 8");
  end

  logic [1:0]           state;
  logic [N_MASTERS-1:0] grant;
  logic [PTR_W-1:0]     ptr;
  logic [WD_W-1:0]      wd_cnt;

  // ptr doubles as the granted index while BUSY/ABORT, since both are loaded together
  logic                 any_req;
  logic                 found;
  logic [PTR_W-1:0]     winner;
  logic [N_MASTERS-1:0] grant_nxt;
  int unsigned          ptr_u;
  int unsigned          cand;

  always_comb begin
    any_req   = |bus.m_cyc_i;
    found     = 1'b0;
    winner    = ptr;
    grant_nxt = '0;
    ptr_u     = 32'(ptr);
    cand      = 0;
    for (int unsigned off = 1; off <= N_MASTERS; off++) begin
      cand = ptr_u + off;
      if (cand >= N_MASTERS) cand = cand - N_MASTERS;
      for (int unsigned k = 0; k < N_MASTERS; k++) begin
        if (!found && bus.m_cyc_i[k] && cand == k) begin
          found  = 1'b1;
          winner = PTR_W'(k);
        end
      end
    end
    for (int unsigned k = 0; k < N_MASTERS; k++) begin
      grant_nxt[k] = (32'(winner) == k);
    end
  end

  logic              g_cyc;
  logic              g_stb;
  logic              g_we;
  logic [SEL_W-1:0]  g_sel;
  logic [ADDR_W-1:0] g_adr;
  logic [DATA_W-1:0] g_dat;

  always_comb begin
    g_cyc = 1'b0;
    g_stb = 1'b0;
    g_we  = 1'b0;
    g_sel = '0;
    g_adr = '0;
    g_dat = '0;
    for (int unsigned k = 0; k < N_MASTERS; k++) begin
      if (32'(ptr) == k) begin
        g_cyc = bus.m_cyc_i[k];
        g_stb = bus.m_stb_i[k];
        g_we  = bus.m_we_i[k];
        g_sel = bus.m_sel_i[k*SEL_W +: SEL_W];
        g_adr = bus.m_adr_i[k*ADDR_W +: ADDR_W];
        g_dat = bus.m_dat_i[k*DATA_W +: DATA_W];
      end
    end
  end

  logic s_active;
  logic stall;
  logic timeout_hit;
  logic err_fwd;

  always_comb begin
    s_active    = (state == ST_BUSY) && g_cyc;
    stall       = s_active && g_stb && !bus.s_ack_i && !bus.s_err_i;
    timeout_hit = (TIMEOUT != 0) && stall && (wd_cnt == WD_LAST);
    err_fwd     = (s_active && bus.s_err_i && !bus.s_ack_i) || (state == ST_ABORT);

    bus.s_cyc_o = s_active;
    bus.s_stb_o = s_active && g_stb;
    bus.s_we_o  = s_active && g_we;
    bus.s_sel_o = s_active ? g_sel : '0;
    bus.s_adr_o = s_active ? g_adr : '0;
    bus.s_dat_o = s_active ? g_dat : '0;

    bus.m_dat_o = bus.s_dat_i;
    bus.m_ack_o = grant & {N_MASTERS{s_active && bus.s_ack_i}};
    bus.m_err_o = grant & {N_MASTERS{err_fwd}};
    bus.grant_o = grant;
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state  <= ST_IDLE;
      grant  <= '0;
      ptr    <= PTR_W'(N_MASTERS - 1);
      wd_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          wd_cnt <= '0;
          if (any_req) begin
            grant <= grant_nxt;
            ptr   <= winner;
            state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (!g_cyc) begin
            state  <= ST_IDLE;
            grant  <= '0;
            wd_cnt <= '0;
          end else if (timeout_hit) begin
            state  <= ST_ABORT;
            wd_cnt <= '0;
          end else if (stall && TIMEOUT != 0) begin
            wd_cnt <= wd_cnt + WD_W'(1);
          end else begin
            wd_cnt <= '0;
          end
        end
        ST_ABORT: begin
          state  <= ST_IDLE;
          grant  <= '0;
          wd_cnt <= '0;
        end
        default: begin
          state  <= ST_IDLE;
          grant  <= '0;
          wd_cnt <= '0;
        end
      endcase
    end
  end

  a_grant_onehot0: assert property (@(posedge clk) $onehot0(grant));

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter: 2 masters, TIMEOUT=4, hand-computed expectations.
module tb_wb_rr_arbiter;

  logic clk;
  logic rst_i;
  int unsigned n_total;
  int unsigned n_bad;
  logic [1:0] exp_g;

  wb_rr_arbiter_if #(.N_MASTERS(2), .ADDR_W(32), .DATA_W(32)) bus ();

  wb_rr_arbiter #(
    .N_MASTERS(2),
    .ADDR_W   (32),
    .DATA_W   (32),
    .TIMEOUT  (4)
  ) dut (
    .clk  (clk),
    .rst_i(rst_i),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input int unsigned k, input logic cyc, input logic stb, input logic we,
                       input logic [3:0] sel, input logic [31:0] adr, input logic [31:0] dat);
    bus.m_cyc_i[k]          = cyc;
    bus.m_stb_i[k]          = stb;
    bus.m_we_i[k]           = we;
    bus.m_sel_i[k*4 +: 4]   = sel;
    bus.m_adr_i[k*32 +: 32] = adr;
    bus.m_dat_i[k*32 +: 32] = dat;
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst_i   = 1'b1;
    bus.m_cyc_i = '0;
    bus.m_stb_i = '0;
    bus.m_we_i  = '0;
    bus.m_sel_i = '0;
    bus.m_adr_i = '0;
    bus.m_dat_i = '0;
    bus.s_dat_i = '0;
    bus.s_ack_i = 1'b0;
    bus.s_err_i = 1'b0;

    tick();
    tick();
    #1;
    check("rst_grant", 64'(bus.grant_o), 64'h0);
    check("rst_scyc",  64'(bus.s_cyc_o), 64'h0);
    check("rst_sstb",  64'(bus.s_stb_o), 64'h0);
    check("rst_ack",   64'(bus.m_ack_o), 64'h0);
    check("rst_err",   64'(bus.m_err_o), 64'h0);

    // both request while still in reset; master 0 wins first
    bus.m_cyc_i = 2'b11;
    tick();
    rst_i = 1'b0;
    #1;
    check("t1_idle_grant", 64'(bus.grant_o), 64'h0);
    tick();
    check("t1_grant_m0", 64'(bus.grant_o), 64'h1);
    check("t1_scyc",     64'(bus.s_cyc_o), 64'h1);
    bus.m_cyc_i = 2'b10;
    #1;
    check("t1_drop_scyc",  64'(bus.s_cyc_o), 64'h0);
    check("t1_drop_grant", 64'(bus.grant_o), 64'h1);
    tick();
    check("t1_bubble", 64'(bus.grant_o), 64'h0);
    tick();
    check("t1_grant_m1", 64'(bus.grant_o), 64'h2);
    check("t1_scyc_m1",  64'(bus.s_cyc_o), 64'h1);
    bus.m_cyc_i = 2'b00;
    tick();
    check("t1_release", 64'(bus.grant_o), 64'h0);

    // master 0 read, slave ACKs on the third STB cycle
    set_m(0, 1'b1, 1'b1, 1'b0, 4'hF, 32'h100, 32'h0);
    tick();
    check("t2_grant", 64'(bus.grant_o), 64'h1);
    check("t2_sstb",  64'(bus.s_stb_o), 64'h1);
    check("t2_sadr",  64'(bus.s_adr_o), 64'h100);
    check("t2_swe",   64'(bus.s_we_o),  64'h0);
    check("t2_ack_c1", 64'(bus.m_ack_o), 64'h0);
    tick();
    check("t2_ack_c2", 64'(bus.m_ack_o), 64'h0);
    tick();
    bus.s_ack_i = 1'b1;
    bus.s_dat_i = 32'hDEADBEEF;
    #1;
    check("t2_ack",  64'(bus.m_ack_o), 64'h1);
    check("t2_rdat", 64'(bus.m_dat_o), 64'hDEADBEEF);
    check("t2_err",  64'(bus.m_err_o), 64'h0);
    tick();
    bus.s_ack_i = 1'b0;
    set_m(0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    #1;
    check("t2_ack_off", 64'(bus.m_ack_o), 64'h0);
    check("t2_scyc_off", 64'(bus.s_cyc_o), 64'h0);
    tick();
    check("t2_idle", 64'(bus.grant_o), 64'h0);

    // master 1 write; master 0 request during it has to wait
    set_m(1, 1'b1, 1'b1, 1'b1, 4'b0011, 32'h200, 32'h1234);
    tick();
    check("t3_grant", 64'(bus.grant_o), 64'h2);
    check("t3_swe",   64'(bus.s_we_o),  64'h1);
    check("t3_ssel",  64'(bus.s_sel_o), 64'h3);
    check("t3_sadr",  64'(bus.s_adr_o), 64'h200);
    check("t3_sdat",  64'(bus.s_dat_o), 64'h1234);
    set_m(0, 1'b1, 1'b1, 1'b0, 4'hF, 32'h300, 32'h0);
    #1;
    check("t3_hold_grant", 64'(bus.grant_o), 64'h2);
    check("t3_hold_sadr",  64'(bus.s_adr_o), 64'h200);
    tick();
    check("t3_wait_grant", 64'(bus.grant_o), 64'h2);
    check("t3_wait_ack",   64'(bus.m_ack_o), 64'h0);
    bus.s_ack_i = 1'b1;
    #1;
    check("t3_ack_m1", 64'(bus.m_ack_o), 64'h2);
    tick();
    bus.s_ack_i = 1'b0;
    set_m(1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    #1;
    check("t3_drop_scyc", 64'(bus.s_cyc_o), 64'h0);
    tick();
    check("t3_bubble", 64'(bus.grant_o), 64'h0);
    tick();
    check("t3_grant_m0", 64'(bus.grant_o), 64'h1);
    check("t3_sadr_m0",  64'(bus.s_adr_o), 64'h300);
    check("t3_swe_m0",   64'(bus.s_we_o),  64'h0);
    bus.s_ack_i = 1'b1;
    #1;
    check("t3_ack_m0", 64'(bus.m_ack_o), 64'h1);
    tick();
    bus.s_ack_i = 1'b0;
    set_m(0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    tick();

    // dead slave: four stalled STB cycles, then one ABORT cycle with ERR
    set_m(1, 1'b1, 1'b1, 1'b0, 4'hF, 32'h400, 32'h0);
    tick();
    check("t4_grant", 64'(bus.grant_o), 64'h2);
    check("t4_err_s1", 64'(bus.m_err_o), 64'h0);
    tick();
    check("t4_err_s2", 64'(bus.m_err_o), 64'h0);
    tick();
    check("t4_err_s3", 64'(bus.m_err_o), 64'h0);
    tick();
    check("t4_err_s4",  64'(bus.m_err_o), 64'h0);
    check("t4_scyc_s4", 64'(bus.s_cyc_o), 64'h1);
    tick();
    check("t4_abort_err",   64'(bus.m_err_o), 64'h2);
    check("t4_abort_scyc",  64'(bus.s_cyc_o), 64'h0);
    check("t4_abort_sstb",  64'(bus.s_stb_o), 64'h0);
    check("t4_abort_grant", 64'(bus.grant_o), 64'h2);
    check("t4_abort_ack",   64'(bus.m_ack_o), 64'h0);
    set_m(1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    tick();
    check("t4_post_err",   64'(bus.m_err_o), 64'h0);
    check("t4_post_grant", 64'(bus.grant_o), 64'h0);

    // ACK on the fourth cycle beats the watchdog
    set_m(0, 1'b1, 1'b1, 1'b0, 4'hF, 32'h500, 32'h0);
    tick();
    check("t4b_grant", 64'(bus.grant_o), 64'h1);
    tick();
    tick();
    tick();
    bus.s_ack_i = 1'b1;
    #1;
    check("t4b_ack", 64'(bus.m_ack_o), 64'h1);
    check("t4b_err", 64'(bus.m_err_o), 64'h0);
    tick();
    bus.s_ack_i = 1'b0;
    set_m(0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    #1;
    check("t4b_no_abort", 64'(bus.m_err_o), 64'h0);
    check("t4b_grant_held", 64'(bus.grant_o), 64'h1);
    tick();
    check("t4b_idle", 64'(bus.grant_o), 64'h0);

    // slave ACK and ERR together forward ACK only; ERR alone forwards ERR
    set_m(1, 1'b1, 1'b1, 1'b0, 4'hF, 32'h600, 32'h0);
    tick();
    bus.s_ack_i = 1'b1;
    bus.s_err_i = 1'b1;
    #1;
    check("te_both_ack", 64'(bus.m_ack_o), 64'h2);
    check("te_both_err", 64'(bus.m_err_o), 64'h0);
    bus.s_ack_i = 1'b0;
    #1;
    check("te_err_ack", 64'(bus.m_ack_o), 64'h0);
    check("te_err_err", 64'(bus.m_err_o), 64'h2);
    bus.s_err_i = 1'b0;
    set_m(1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    tick();
    check("te_idle", 64'(bus.grant_o), 64'h0);

    // both masters keep requesting with single-beat transfers: grants alternate
    set_m(0, 1'b1, 1'b1, 1'b0, 4'hF, 32'h700, 32'h0);
    set_m(1, 1'b1, 1'b1, 1'b0, 4'hF, 32'h800, 32'h0);
    exp_g = 2'b01;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t5_grant", 64'(bus.grant_o), 64'(exp_g));
      check("t5_sadr",  64'(bus.s_adr_o), (exp_g == 2'b01) ? 64'h700 : 64'h800);
      bus.s_ack_i = 1'b1;
      #1;
      check("t5_ack", 64'(bus.m_ack_o), 64'(exp_g));
      tick();
      bus.s_ack_i = 1'b0;
      bus.m_cyc_i = ~exp_g;
      #1;
      check("t5_drop_scyc", 64'(bus.s_cyc_o), 64'h0);
      tick();
      check("t5_bubble", 64'(bus.grant_o), 64'h0);
      bus.m_cyc_i = 2'b11;
      exp_g = ~exp_g;
    end

    // reset mid-BUSY with master 1 granted; master 0 must win afterwards
    bus.m_cyc_i = 2'b10;
    tick();
    check("t5r_grant_m1", 64'(bus.grant_o), 64'h2);
    check("t5r_scyc",     64'(bus.s_cyc_o), 64'h1);
    bus.m_cyc_i = 2'b11;
    rst_i = 1'b1;
    tick();
    check("t5r_rst_grant", 64'(bus.grant_o), 64'h0);
    check("t5r_rst_scyc",  64'(bus.s_cyc_o), 64'h0);
    check("t5r_rst_err",   64'(bus.m_err_o), 64'h0);
    rst_i = 1'b0;
    tick();
    check("t5r_grant_m0", 64'(bus.grant_o), 64'h1);
    check("t5r_sadr_m0",  64'(bus.s_adr_o), 64'h700);
    bus.m_cyc_i = 2'b00;
    bus.m_stb_i = 2'b00;
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
